// File: rtl/axil_pkg.sv
// axil_pkg: response codes, FSM states and byte-merge helper shared by the AXI4-Lite register slave
package axil_pkg;
    localparam int RESP_OKAY = 0;
    localparam int RESP_SLVERR = 2;
    localparam int MAX_DW = 256;
    localparam int MAX_NB = MAX_DW / 8;
    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_NB-1:0] strb
    );
        logic [MAX_DW-1:0] m;
        for (int i = 0; i < MAX_NB; i++) m[i*8 +: 8] = strb[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return m;
    endfunction
endpackage

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite slave holding NUM_REGS byte-strobed word registers with registered reads
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int NUM_REGS = 4,
    parameter int BASE_ADDR = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]          s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [RESP_WIDTH-1:0]          s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int BSH = $clog2(NB);
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [RESP_WIDTH-1:0] OKAY = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(RESP_SLVERR);

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - ADDR_WIDTH'(BASE_ADDR);
        return (a[BSH-1:0] == '0) && (off < ADDR_WIDTH'(NUM_REGS * NB));
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - ADDR_WIDTH'(BASE_ADDR);
        return IW'(off >> BSH);
    endfunction

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NB-1:0] wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
    logic [IW-1:0] wr_idx, rd_idx;
    logic unused_strb_msb;

    // A channel handshaking this cycle counts as held, so AW and W may complete on the same edge
    assign aw_hs = s_axi_awvalid && awready_q;
    assign w_hs = s_axi_wvalid && wready_q;
    assign ar_hs = s_axi_arvalid && arready_q;
    assign awaddr_d = aw_hs ? s_axi_awaddr : awaddr_q;
    assign wdata_d = w_hs ? s_axi_wdata : wdata_q;
    assign wstrb_d = w_hs ? s_axi_wstrb[NB-1:0] : wstrb_q;
    assign commit = (w_state_q == W_IDLE) && (aw_hs || aw_held_q) && (w_hs || w_held_q);
    assign wr_ok = addr_ok(awaddr_d);
    assign wr_idx = addr_idx(awaddr_d);
    assign rd_ok = addr_ok(s_axi_araddr);
    assign rd_idx = addr_idx(s_axi_araddr);
    assign unused_strb_msb = s_axi_wstrb[NB];

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q || aw_hs;
        w_held_d = w_held_q || w_hs;
        bvalid_d = bvalid_q;
        bresp_d = bresp_q;
        regs_d = regs_q;
        wr_pulse_d = '0;
        if (w_state_q == W_RESP) begin
            w_state_d = s_axi_bready ? W_IDLE : W_RESP;
            bvalid_d = !s_axi_bready;
        end else if (commit) begin
            w_state_d = W_RESP;
            aw_held_d = 1'b0;
            w_held_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d = wr_ok ? OKAY : SLVERR;
            if (wr_ok) begin
                regs_d[wr_idx] = DATA_WIDTH'(strb_merge(MAX_DW'(regs_q[wr_idx]), MAX_DW'(wdata_d), MAX_NB'(wstrb_d)));
                wr_pulse_d[wr_idx] = 1'b1;
            end
        end
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Reads sample regs_q, so a write committing on the same edge is not yet visible
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d = rvalid_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (r_state_q == R_DATA) begin
            r_state_d = s_axi_rready ? R_IDLE : R_DATA;
            rvalid_d = !s_axi_rready;
        end else if (ar_hs) begin
            r_state_d = R_DATA;
            rvalid_d = 1'b1;
            rresp_d = rd_ok ? OKAY : SLVERR;
            rdata_d = rd_ok ? regs_q[rd_idx] : '0;
        end
        arready_d = r_state_d == R_IDLE;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            bresp_q <= '0;
            rresp_q <= '0;
            rdata_q <= '0;
            awaddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wr_pulse_q <= '0;
            regs_q <= {NUM_REGS{RESET_VALUE}};
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            w_held_q <= w_held_d;
            awready_q <= awready_d;
            wready_q <= wready_d;
            arready_q <= arready_d;
            bvalid_q <= bvalid_d;
            rvalid_q <= rvalid_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            awaddr_q <= awaddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q <= regs_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp = rresp_q;
    assign s_axi_rdata = rdata_q;
    assign wr_pulse = wr_pulse_q;
    assign reg_out = regs_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: scoreboard bench for axil_reg_slave (BASE_ADDR 0, four 32-bit registers)
module tb_axil_reg_slave;
    logic clk = 1'b0;
    logic s_axi_aresetn = 1'b0;
    logic [7:0] s_axi_awaddr = '0;
    logic s_axi_awvalid = 1'b0;
    logic s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [4:0] s_axi_wstrb = '0;
    logic s_axi_wvalid = 1'b0;
    logic s_axi_wready;
    logic [2:0] s_axi_bresp;
    logic s_axi_bvalid;
    logic s_axi_bready = 1'b0;
    logic [7:0] s_axi_araddr = '0;
    logic s_axi_arvalid = 1'b0;
    logic s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [2:0] s_axi_rresp;
    logic s_axi_rvalid;
    logic s_axi_rready = 1'b0;
    logic [127:0] reg_out;
    logic [3:0] wr_pulse;

    always #5 clk = ~clk;

    axil_reg_slave dut (
        .s_axi_aclk(clk), .s_axi_aresetn(s_axi_aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    typedef struct { logic [2:0] resp; logic [3:0] pulse; logic [127:0] regs; } bexp_t;
    typedef struct { logic [2:0] resp; logic [31:0] data; } rexp_t;
    bexp_t bq[$];
    rexp_t rq[$];
    logic [31:0] m [4] = '{default: 32'h0};
    int n_chk = 0;
    int n_pass = 0;
    logic prev_b = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit a_ok(input logic [7:0] a);
        return a[1:0] == 2'b00 && a < 8'h10;
    endfunction

    task automatic expect_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
        bexp_t e;
        e.resp = a_ok(a) ? 3'd0 : 3'd2;
        e.pulse = 4'b0;
        if (a_ok(a)) begin
            for (int i = 0; i < 4; i++) if (s[i]) m[a[3:2]][8*i +: 8] = d[8*i +: 8];
            e.pulse = 4'b0001 << a[3:2];
        end
        e.regs = {m[3], m[2], m[1], m[0]};
        bq.push_back(e);
    endtask

    task automatic expect_read(input logic [7:0] a);
        rexp_t e;
        e.resp = a_ok(a) ? 3'd0 : 3'd2;
        e.data = a_ok(a) ? m[a[3:2]] : 32'h0;
        rq.push_back(e);
    endtask

    task automatic send_aw(input logic [7:0] a, input int dly);
        int n;
        repeat (dly) @(posedge clk);
        #1;
        s_axi_awaddr = a;
        s_axi_awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_awready && n < 60);
        chk("aw_accept", s_axi_awready, 1'b1);
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [4:0] s, input int dly);
        int n;
        repeat (dly) @(posedge clk);
        #1;
        s_axi_wdata = d;
        s_axi_wstrb = s;
        s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_wready && n < 60);
        chk("w_accept", s_axi_wready, 1'b1);
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] a, input int dly);
        int n;
        repeat (dly) @(posedge clk);
        #1;
        s_axi_araddr = a;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_arready && n < 60);
        chk("ar_accept", s_axi_arready, 1'b1);
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic accept_b(input int dly);
        int n;
        repeat (dly) @(posedge clk);
        #1;
        s_axi_bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 60);
        chk("b_arrive", s_axi_bvalid, 1'b1);
        @(posedge clk);
        #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic accept_r(input int dly);
        int n;
        repeat (dly) @(posedge clk);
        #1;
        s_axi_rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axi_rvalid && n < 60);
        chk("r_arrive", s_axi_rvalid, 1'b1);
        @(posedge clk);
        #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        expect_write(a, d, s);
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
        fork
            accept_b(b_dly);
            begin @(negedge clk); chk("b_latency", s_axi_bvalid, 1'b1); end
        join
    endtask

    task automatic do_read(input logic [7:0] a, input int ar_dly, input int r_dly, input bit push);
        if (push) expect_read(a);
        send_ar(a, ar_dly);
        accept_r(r_dly);
    endtask

    // Monitor: compares every presented response against the head of its scoreboard queue
    always @(negedge clk) begin
        if (s_axi_bvalid) begin
            if (bq.size() == 0) chk("b_unexpected", s_axi_bvalid, 1'b0);
            else begin
                chk("bresp", s_axi_bresp, bq[0].resp);
                chk("b_readies_low", {s_axi_awready, s_axi_wready}, 2'b00);
                if (!prev_b) begin
                    chk("wr_pulse", wr_pulse, bq[0].pulse);
                    chk("reg_out", reg_out, bq[0].regs);
                end else chk("wr_pulse_once", wr_pulse, 4'b0);
                if (s_axi_bready) void'(bq.pop_front());
            end
        end else chk("wr_pulse_idle", wr_pulse, 4'b0);
        prev_b <= s_axi_bvalid;
        if (s_axi_rvalid) begin
            if (rq.size() == 0) chk("r_unexpected", s_axi_rvalid, 1'b0);
            else begin
                chk("rdata", s_axi_rdata, rq[0].data);
                chk("rresp", s_axi_rresp, rq[0].resp);
                chk("r_arready_low", s_axi_arready, 1'b0);
                if (s_axi_rready) void'(rq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a;
        int sel;
        #17;
        chk("rst_awready", s_axi_awready, 1'b0);
        chk("rst_arready", s_axi_arready, 1'b0);
        chk("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        chk("rst_regs", reg_out, 128'h0);
        chk("rst_rdata", s_axi_rdata, 32'h0);
        #5 s_axi_aresetn = 1'b1;
        #1 chk("rel_wready_wait", s_axi_wready, 1'b0);
        @(posedge clk);
        #1;
        chk("rel_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        do_write(8'h04, 32'h12345678, 5'h0F, 0, 0, 0);
        do_read(8'h04, 0, 4, 1);
        fork
            do_write(8'h08, 32'hA5A5A5A5, 5'h03, 3, 0, 0);
            begin
                @(posedge clk);
                @(negedge clk);
                chk("w_first_wready", s_axi_wready, 1'b0);
                chk("w_first_awready", s_axi_awready, 1'b1);
            end
        join
        do_read(8'h08, 0, 0, 1);
        do_write(8'h10, 32'hFFFFFFFF, 5'h0F, 0, 0, 0);
        do_read(8'h06, 0, 0, 1);
        do_write(8'h00, 32'h0BADF00D, 5'h10, 0, 1, 0);
        expect_read(8'h04);
        fork
            do_write(8'h04, 32'hDEADBEEF, 5'h0F, 0, 0, 0);
            do_read(8'h04, 0, 0, 0);
        join
        do_read(8'h04, 0, 1, 1);
        fork
            do_write(8'h00, 32'h11112222, 5'h0F, 0, 0, 6);
            begin
                repeat (2) @(posedge clk);
                do_write(8'h0C, 32'h33334444, 5'h0F, 0, 0, 0);
            end
        join
        do_read(8'h0C, 0, 0, 1);
        expect_write(8'h0C, 32'hCAFEF00D, 5'h0F);
        fork
            send_aw(8'h0C, 0);
            send_w(32'hCAFEF00D, 5'h0F, 0);
        join
        #3;
        chk("pre_rst_bvalid", s_axi_bvalid, 1'b1);
        s_axi_aresetn = 1'b0;
        #1;
        chk("async_rst_bvalid", s_axi_bvalid, 1'b0);
        chk("async_rst_pulse", wr_pulse, 4'b0);
        chk("async_rst_regs", reg_out, 128'h0);
        chk("async_rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        bq.delete();
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        repeat (2) @(posedge clk);
        #3 s_axi_aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("rerel_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        do_write(8'h08, 32'h5A5A0F0F, 5'h0F, 0, 0, 0);
        do_read(8'h08, 0, 0, 1);
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 7));
            a = sel < 4 ? 8'(sel * 4) : (sel == 4 ? 8'h10 : (sel == 5 ? 8'($urandom_range(0, 15)) : 8'($urandom)));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                do_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1);
        end
        for (int i = 0; i < 4; i++) do_read(8'(i * 4), 0, 0, 1);
        repeat (3) @(posedge clk);
        chk("bq_drained", 32'(bq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite register-bank slave that sits directly downstream of the bus interconnect, on its m1 or m2 master port.
- Holds NUM_REGS word registers at BASE_ADDR, with byte-strobed writes and registered reads.
- Exposes register contents and per-register write pulses to the surrounding logic.
- Two instances are used: one at base 0x00 (first master port) and one at base 0x10 (second master port).

Parameters:
DATA_WIDTH, 32, data bus width (multiple of 8)
ADDR_WIDTH, 8, address width
RESP_WIDTH, 3, response field width; OKAY=0, SLVERR=2
NUM_REGS, 4, number of word registers (power of 2)
BASE_ADDR, 0, byte address of register 0 (aligned to NUM_REGS*DATA_WIDTH/8)
RESET_VALUE, 0, reset value of every register

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8+1  byte strobes; bit i enables byte i; MSB unused and ignored
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  RESP_WIDTH  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  RESP_WIDTH  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  NUM_REGS  one-cycle pulse per register on a committed write

Behaviour:
- Reset (async assert, sync release):
  - All ready/valid outputs, wr_pulse, bresp, rresp and rdata go to 0 immediately.
  - Registers load RESET_VALUE; both FSMs go to idle.
  - Ready outputs rise on the first clock edge after release.
- Decode:
  - off = addr - BASE_ADDR. The address is valid iff addr[1:0]==0 and off < NUM_REGS*DATA_WIDTH/8.
  - Register index = off >> 2.
  - Invalid address -> SLVERR.
- Write FSM states:
  - W_IDLE: awready=1, wready=1. AW and W are accepted independently, in either order or in the same cycle.
    - Each accepted channel is latched and its ready drops on that edge.
    - On the edge where both address and data are held (same edge as the last handshake): go to W_RESP.
  - Entering W_RESP:
    - If the address is valid, the indexed register updates byte-wise where wstrb[i]=1 and wr_pulse[idx]=1 for exactly one cycle.
    - bvalid=1 with bresp=OKAY, or SLVERR with no register change and no pulse.
    - Latency: bvalid is high the cycle after the final handshake.
  - W_RESP: awready=wready=0. bvalid and bresp hold until bvalid&&bready; on that edge bvalid=0, both readies=1, go to W_IDLE.
  - Exactly one outstanding write. A new AW/W is never accepted while in W_RESP.
- Read FSM states:
  - R_IDLE: arready=1. On arvalid&&arready, go to R_DATA: rdata = register[idx] sampled at that edge (or 0 if invalid), rresp = OKAY/SLVERR, rvalid=1, arready=0.
  - R_DATA: rdata, rresp and rvalid hold stable until rvalid&&rready; then rvalid=0, arready=1, go to R_IDLE.
- Read and write FSMs are fully independent.
- Simultaneous write commit and AR accept on the same edge to the same register: the read returns the pre-write value.
- wstrb all-zero on a valid address: OKAY response, registers unchanged, wr_pulse still fires.
- Reset mid-transaction: the transaction is abandoned, no response is issued, and registers return to RESET_VALUE.

Decomposition:
- Package axil_pkg holds:
  - RESP_OKAY=0, RESP_SLVERR=2
  - write state enum {W_IDLE, W_RESP}
  - read state enum {R_IDLE, R_DATA}
  - function strb_merge(old, new, strb) returning the byte-merged word
- No sub-module: the register array and both FSMs live in one module.

Test Plan:
- AW 0x04 and W 0x12345678 / wstrb 0xF in the same cycle, bready=1 -> bvalid one cycle later with bresp=0; reg1=0x12345678; wr_pulse=4'b0010 for one cycle.
- W 0xA5A5A5A5 / wstrb 0x3 presented 3 cycles before AW 0x08 -> wready drops at the W handshake, awready stays 1 until AW arrives; reg2=0x0000A5A5; bresp=0.
- AR 0x04 after scenario 1, rready held low 4 cycles -> rvalid=1 and rdata=0x12345678 stable throughout; arready=0 until the R handshake.
- BASE_ADDR=0: write to 0x10 -> bresp=2, all registers unchanged, wr_pulse=0. Read 0x06 -> rresp=2, rdata=0.
- bready held low 5 cycles after a write, second AW/W presented -> awready=wready=0 until the B handshake; second write commits afterwards.
- Assert s_axi_aresetn low mid-cycle while bvalid=1 -> bvalid=0 immediately (asynchronously), reg_out=all RESET_VALUE; after release, a fresh write completes normally.
